// File: rtl/key_time_setter.sv
// Pushbutton front end for the clock display: two-flop sync, debounce,
// press detect and the RUN/SET_HR/SET_MIN/SET_SEC mode FSM.
module key_time_setter #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       KEY_MODE,
  input  logic       KEY_INC,
  input  logic       Tick_1s,
  output logic       Run_En,
  output logic       Inc_Hr,
  output logic       Inc_Min,
  output logic       Inc_Sec,
  output logic [1:0] Mode,
  output logic       Blink
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10,
    SET_SEC = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit 0 carries KEY_MODE, bit 1 carries KEY_INC.
  logic [1:0]            s1_q, s2_q;
  logic [1:0]            deb_q, deb_d;
  logic [1:0]            prev_q;
  logic [1:0]            press_q, press_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

  state_e     state_q, state_d;
  logic       blink_q, blink_d;
  logic [2:0] inc_q, inc_d;

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int k = 0; k < 2; k++) begin
      if (s2_q[k] != deb_q[k]) begin
        if (cnt_q[k] == CNT_MAX) begin
          deb_d[k] = s2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
    press_d = prev_q & ~deb_q;
  end

  always_comb begin
    state_d = state_q;
    blink_d = blink_q;
    inc_d   = 3'b000;
    if (press_q[0]) begin
      case (state_q)
        RUN:     state_d = SET_HR;
        SET_HR:  state_d = SET_MIN;
        SET_MIN: state_d = SET_SEC;
        default: state_d = RUN;
      endcase
      blink_d = 1'b0;
    end else begin
      if (press_q[1]) begin
        case (state_q)
          SET_HR:  inc_d = 3'b100;
          SET_MIN: inc_d = 3'b010;
          SET_SEC: inc_d = 3'b001;
          default: inc_d = 3'b000;
        endcase
      end
      if (state_q == RUN) begin
        blink_d = 1'b0;
      end else if (Tick_1s) begin
        blink_d = ~blink_q;
      end
    end
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      s1_q    <= 2'b11;
      s2_q    <= 2'b11;
      deb_q   <= 2'b11;
      prev_q  <= 2'b11;
      press_q <= 2'b00;
      cnt_q   <= '0;
      state_q <= RUN;
      blink_q <= 1'b0;
      inc_q   <= 3'b000;
    end else begin
      s1_q    <= {KEY_INC, KEY_MODE};
      s2_q    <= s1_q;
      deb_q   <= deb_d;
      prev_q  <= deb_q;
      press_q <= press_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      blink_q <= blink_d;
      inc_q   <= inc_d;
    end
  end

  assign Run_En  = Tick_1s & (state_q == RUN);
  assign Inc_Hr  = inc_q[2];
  assign Inc_Min = inc_q[1];
  assign Inc_Sec = inc_q[0];
  assign Mode    = state_q;
  assign Blink   = blink_q;

endmodule

// File: tb/tb_key_time_setter.sv
// Scoreboard bench for key_time_setter with a 4-cycle debounce.
// Observed word is {Mode, Inc_Hr, Inc_Min, Inc_Sec, Blink}.
module tb_key_time_setter;

  logic       Clk = 1'b0;
  logic       Clr;
  logic       KEY_MODE;
  logic       KEY_INC;
  logic       Tick_1s;
  logic       Run_En;
  logic       Inc_Hr;
  logic       Inc_Min;
  logic       Inc_Sec;
  logic [1:0] Mode;
  logic       Blink;

  logic [5:0] obs;
  logic [5:0] exp_q[$];
  logic [5:0] e;
  int         vectors = 0;
  int         miscompares = 0;

  assign obs = {Mode, Inc_Hr, Inc_Min, Inc_Sec, Blink};

  key_time_setter #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(20)
  ) dut (
    .Clk(Clk),
    .Clr(Clr),
    .KEY_MODE(KEY_MODE),
    .KEY_INC(KEY_INC),
    .Tick_1s(Tick_1s),
    .Run_En(Run_En),
    .Inc_Hr(Inc_Hr),
    .Inc_Min(Inc_Min),
    .Inc_Sec(Inc_Sec),
    .Mode(Mode),
    .Blink(Blink)
  );

  always #5 Clk = ~Clk;

  task automatic quiet_mode_press();
    for (int c = 0; c < 20; c++) begin
      KEY_MODE = (c < 10) ? 1'b0 : 1'b1;
      @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    for (int c = 1; c <= 4; c++) begin
      Tick_1s = c[0];
      exp_q.push_back(6'b00_000_0);
      #1;
      vectors++;
      if (Run_En !== Tick_1s) begin
        miscompares++;
        $display("FAIL reset_run_en c=%0d got %b want %b",
                 c, Run_En, Tick_1s);
      end
      @(posedge Clk);
      @(negedge Clk);
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL reset_state c=%0d got %b want %b", c, obs, e);
      end
    end
    Tick_1s = 1'b0;
    Clr = 1'b1;
  endtask

  task automatic test_glitch();
    for (int c = 1; c <= 12; c++) begin
      KEY_MODE = (c <= 3) ? 1'b0 : 1'b1;
      Tick_1s  = (c == 2 || c == 5);
      exp_q.push_back(6'b00_000_0);
      #1;
      vectors++;
      if (Run_En !== Tick_1s) begin
        miscompares++;
        $display("FAIL glitch_run_en c=%0d got %b want %b",
                 c, Run_En, Tick_1s);
      end
      @(posedge Clk);
      @(negedge Clk);
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL glitch c=%0d got %b want %b", c, obs, e);
      end
    end
    Tick_1s = 1'b0;
  endtask

  task automatic test_mode_hold();
    for (int c = 1; c <= 30; c++) begin
      KEY_MODE = (c <= 20) ? 1'b0 : 1'b1;
      exp_q.push_back((c >= 8) ? 6'b01_000_0 : 6'b00_000_0);
      @(posedge Clk);
      @(negedge Clk);
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL mode_hold c=%0d got %b want %b", c, obs, e);
      end
    end
  endtask

  task automatic test_inc_min();
    logic blk;
    quiet_mode_press();
    blk = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      KEY_INC = (c <= 12) ? 1'b0 : 1'b1;
      Tick_1s = (c == 2 || c == 5 || c == 8);
      if (Tick_1s) blk = ~blk;
      exp_q.push_back({2'b10, 1'b0, (c == 8), 1'b0, blk});
      #1;
      vectors++;
      if (Run_En !== 1'b0) begin
        miscompares++;
        $display("FAIL set_run_en c=%0d got %b want 0", c, Run_En);
      end
      @(posedge Clk);
      @(negedge Clk);
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL inc_min c=%0d got %b want %b", c, obs, e);
      end
    end
    Tick_1s = 1'b0;
  endtask

  task automatic test_back_to_back();
    quiet_mode_press();
    for (int c = 1; c <= 24; c++) begin
      KEY_MODE = (c <= 12) ? 1'b0 : 1'b1;
      KEY_INC  = KEY_MODE;
      exp_q.push_back((c >= 8) ? 6'b00_000_0 : 6'b11_000_0);
      @(posedge Clk);
      @(negedge Clk);
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL mode_inc_same c=%0d got %b want %b", c, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    quiet_mode_press();
    vectors++;
    if (Mode !== 2'b01) begin
      miscompares++;
      $display("FAIL pre_reset_mode got %b want 01", Mode);
    end
    for (int c = 1; c <= 26; c++) begin
      KEY_INC = (c <= 16) ? 1'b0 : 1'b1;
      if (c == 4) Clr = 1'b0;
      if (c == 6) Clr = 1'b1;
      if (c == 4) begin
        #1;
        vectors++;
        if (Mode !== 2'b00) begin
          miscompares++;
          $display("FAIL async_clr_mode got %b want 00", Mode);
        end
      end
      exp_q.push_back((c < 4) ? 6'b01_000_0 : 6'b00_000_0);
      @(posedge Clk);
      @(negedge Clk);
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL reset_mid c=%0d got %b want %b", c, obs, e);
      end
    end
  endtask

  initial begin
    Clr      = 1'b0;
    KEY_MODE = 1'b1;
    KEY_INC  = 1'b1;
    Tick_1s  = 1'b0;
    @(negedge Clk);
    test_reset();
    test_glitch();
    test_mode_hold();
    test_inc_min();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
